mux8_rr_scheduler: RTL
======================

Name: mux8_rr_scheduler

Overview:
Round-robin scheduler that shares one 8:1 single-bit selector datapath among 8 requesters. It is the sequencing companion to the combinational 8-input/3-select multiplexer. The block arbitrates requests and drives the 3-bit select, with select bit 2 as MSB. It also samples the selected data bit into a register. A hold timeout stops any one requester from monopolising the selector.

Parameters:
HOLD_MAX, 8, max consecutive GRANT cycles per grant before forced release; legal 1..255
PTR_RESET, 0, round-robin pointer value after reset; legal 0..7

Ports:
clock  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clock
req  input  8  request vector, bit n = requester n
done  input  1  granted requester finished, release selector
data_in  input  8  datapath inputs; data_in[n] is mux input n
sel  output  3  select to the 8:1 datapath; registered
gnt  output  8  one-hot grant; all zero when not granting; registered
gnt_valid  output  1  high in GRANT state
dout  output  1  registered data_in[sel]
dout_valid  output  1  high the cycle after each GRANT cycle (dout fresh)
timeout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- Reset values: state=IDLE, ptr=PTR_RESET, sel=0, gnt=0, gnt_valid=0, dout=0, dout_valid=0, timeout=0, hold_cnt=0.
- Reset has priority over every other event. Asserting reset mid-grant returns all state to reset values at that edge. There is no completion and no timeout pulse.
- States: IDLE, GRANT, GAP.
- Arbitration function: scan indices ptr, ptr+1, … ptr+7 (mod 8). The winner is the first index with req set.
- IDLE:
  - If req==0: stay in IDLE.
  - Otherwise: next state GRANT; sel<=winner; gnt<=one-hot(winner); hold_cnt<=0.
  - Latency: request seen in cycle t, gnt_valid high in cycle t+1.
- GRANT:
  - gnt_valid=1. Each cycle: dout<=data_in[sel]; hold_cnt increments.
  - Exit conditions, evaluated each cycle:
    - (a) done=1
    - (b) req[sel]=0 (requester withdrew)
    - (c) hold_cnt==HOLD_MAX-1
  - On any exit:
    - next state GAP; gnt<=0.
    - sel holds its value.
    - ptr<=(sel+1) mod 8.
    - timeout<=1 only when (c) is the cause and neither (a) nor (b) holds in the same cycle.
  - HOLD_MAX=1 gives exactly one GRANT cycle per grant.
- GAP (exactly one cycle):
  - gnt_valid=0; timeout returns to 0 after this cycle.
  - Run arbitration with the updated ptr. If any req: next GRANT with the new winner, same as from IDLE. Otherwise: next IDLE.
  - Back-to-back grants are therefore separated by one idle cycle. The gap guarantees a select-change settling cycle.
- dout_valid is a 1-cycle delay of gnt_valid. dout holds its last value outside GRANT.
- sel is never changed while gnt_valid=1.
- gnt==one-hot(sel) whenever gnt_valid=1; otherwise gnt==0.
- ptr wrap: sel=7 on exit gives ptr=0.
- A req change during GRANT for non-granted bits has no effect until the next arbitration.
- A req asserted in the same cycle as the GAP arbitration is eligible.

Test Plan:
- Reset then req=8'h10: cycle+1 sel=4, gnt=8'h10, gnt_valid=1; data_in[4]=1 gives dout=1 with dout_valid=1 the next cycle.
- req=8'hFF held, done pulsed on every 2nd GRANT cycle: grant order 0,1,2,…,7,0. Each grant lasts 2 cycles, with 1 GAP cycle between grants. No timeout.
- HOLD_MAX=8, req=8'h01 held, done=0: GRANT lasts exactly 8 cycles, timeout pulses once, GAP follows, then 0 is re-granted (sole requester).
- done and hold_cnt==HOLD_MAX-1 in the same cycle: exit to GAP, timeout stays 0.
- Granted to 7, req=8'h81, done: next grant is 0 (ptr wrapped to 0). sel stays 7 through GAP, then becomes 0.
- Reset asserted in 3rd GRANT cycle: next cycle gnt=0, sel=0, gnt_valid=0, timeout=0, ptr=PTR_RESET.

Source files
------------

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 single-bit selector among 8 requesters.
// Drives the registered select/grant, samples the selected data bit, and
// force-releases a grant that is held for HOLD_MAX consecutive cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no grant outstanding, arbitrate on any request
// S_GRANT | one requester owns the selector, dout sampled every cycle
// S_GAP   | single settling cycle after release, arbitrate with new ptr
module mux8_rr_scheduler #(
  parameter int HOLD_MAX  = 8,
  parameter int PTR_RESET = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  input  logic [7:0] data_in,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       dout,
  output logic       dout_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [2:0] PTR_INIT  = 3'(PTR_RESET);

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic [2:0] win;
  logic [2:0] idx;
  logic       any_req;
  logic       exit_done;
  logic       exit_wdraw;
  logic       exit_hold;
  logic       exit_any;

  // Round-robin pick: scan from ptr upward; walking the offsets from high to
  // low lets the smallest offset with a request overwrite the others.
  always_comb begin
    win     = ptr;
    idx     = ptr;
    any_req = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) begin
        win     = idx;
        any_req = 1'b1;
      end
    end
  end

  // Release causes while granting; timeout only flags a pure hold expiry.
  always_comb begin
    exit_done  = done;
    exit_wdraw = ~req[sel];
    exit_hold  = (hold_cnt == HOLD_LAST);
    exit_any   = exit_done | exit_wdraw | exit_hold;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= PTR_INIT;
      sel        <= 3'd0;
      gnt        <= 8'd0;
      gnt_valid  <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      timeout    <= 1'b0;
      hold_cnt   <= 8'd0;
    end else begin
      timeout    <= 1'b0;
      dout_valid <= gnt_valid;
      case (state)
        S_IDLE, S_GAP: begin
          if (any_req) begin
            state     <= S_GRANT;
            sel       <= win;
            gnt       <= 8'b1 << win;
            gnt_valid <= 1'b1;
            hold_cnt  <= 8'd0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GRANT: begin
          dout     <= data_in[sel];
          hold_cnt <= hold_cnt + 8'd1;
          if (exit_any) begin
            state     <= S_GAP;
            gnt       <= 8'd0;
            gnt_valid <= 1'b0;
            ptr       <= sel + 3'd1;
            timeout   <= exit_hold & ~exit_done & ~exit_wdraw;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
